// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
//
// Bundles the request/response handshake and the memory port of the
// load/store unit. Signal names keep the _i/_o suffixes as seen from the
// unit itself.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1. After that edge the request fields are
// don't-care. resp_valid_o is a one-cycle pulse that cannot be stalled.
//
// Modports:
//   slave  - the load_store_unit (receives requests, drives the memory port)
//   master - the execute stage / memory side (drives requests and read data)
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              is_store_i;
  logic [2:0]        funct3_i;
  logic [31:0]       addr_i;
  logic [31:0]       wdata_i;
  logic              resp_valid_o;
  logic [31:0]       rdata_o;
  logic              fault_o;
  logic              mem_en_o;
  logic              mem_wr_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic [31:0]       mem_data_i;

  modport slave (
    input  req_valid_i, is_store_i, funct3_i, addr_i, wdata_i, mem_data_i,
    output req_ready_o, resp_valid_o, rdata_o, fault_o,
           mem_en_o, mem_wr_en_o, mem_addr_o, mem_data_o
  );

  modport master (
    output req_valid_i, is_store_i, funct3_i, addr_i, wdata_i, mem_data_i,
    input  req_ready_o, resp_valid_o, rdata_o, fault_o,
           mem_en_o, mem_wr_en_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Takes one RV32I load/store at a time, decodes funct3 and runs it against a
// fixed-latency, word-wide, byte-addressed memory. Loads are sign/zero
// extended; byte and halfword stores are read-modify-write because the
// memory always writes a whole word.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      asynchronous reset, active low
//   bus          load_store_unit_if.slave: request/response + memory port
//   dbg_state_o  current FSM state (IDLE=0 READ=1 WRITE=2 FAULT=3 RESP=4)
//
// Parameters:
//   MEM_LATENCY  cycles each memory access is held (>= 2)
//   ADDR_W       memory address width; upper request address bits ignored
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_LATENCY = 6,
  parameter int ADDR_W      = 12
) (
  input  logic               clk_i,
  input  logic               reset_i,
  load_store_unit_if.slave   bus,
  output logic [2:0]         dbg_state_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_FAULT = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam int               CNT_W    = $clog2(MEM_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_store;
  logic [2:0]        r_funct3;
  logic [15:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_fault;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_data;

  logic              w_accept;
  logic              w_fault;
  logic              w_cnt_done;
  logic [31:0]       w_load_data;
  logic [31:0]       w_merge;
  logic              w_unused_addr;

  // Memory wraps the address internally, so the high request bits are dropped.
  assign w_unused_addr = |bus.addr_i[31:ADDR_W];

  assign w_accept   = bus.req_valid_i && (r_state == S_IDLE);
  assign w_cnt_done = (r_cnt == '0);

  // Illegal funct3, unsigned stores and misaligned H/W accesses all fault.
  always_comb begin
    w_fault = 1'b0;
    case (bus.funct3_i)
      F3_B:    w_fault = 1'b0;
      F3_H:    w_fault = bus.addr_i[0];
      F3_W:    w_fault = |bus.addr_i[1:0];
      F3_BU:   w_fault = bus.is_store_i;
      F3_HU:   w_fault = bus.is_store_i | bus.addr_i[0];
      default: w_fault = 1'b1;
    endcase
  end

  // The addressed byte is always in the low lane of the read word.
  always_comb begin
    w_load_data = bus.mem_data_i;
    case (r_funct3)
      F3_B:    w_load_data = {{24{bus.mem_data_i[7]}}, bus.mem_data_i[7:0]};
      F3_BU:   w_load_data = {24'd0, bus.mem_data_i[7:0]};
      F3_H:    w_load_data = {{16{bus.mem_data_i[15]}}, bus.mem_data_i[15:0]};
      F3_HU:   w_load_data = {16'd0, bus.mem_data_i[15:0]};
      default: w_load_data = bus.mem_data_i;
    endcase
  end

  // Only SB/SH reach the merge path; funct3[0] separates H from B.
  // Bytes above the store width are written back with their own values.
  assign w_merge = r_funct3[0] ? {bus.mem_data_i[31:16], r_wdata}
                               : {bus.mem_data_i[31:8],  r_wdata[7:0]};

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_store <= 1'b0;
      r_funct3   <= 3'd0;
      r_wdata    <= 16'd0;
      r_rdata    <= 32'd0;
      r_fault    <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_store <= bus.is_store_i;
            r_funct3   <= bus.funct3_i;
            r_wdata    <= bus.wdata_i[15:0];
            r_mem_addr <= bus.addr_i[ADDR_W-1:0];
            r_cnt      <= CNT_LAST;
            if (w_fault) begin
              r_state <= S_FAULT;
            end else if (bus.is_store_i && (bus.funct3_i == F3_W)) begin
              // Full-word store needs no read; go straight to the write.
              r_state    <= S_WRITE;
              r_mem_data <= bus.wdata_i;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (w_cnt_done) begin
            if (r_is_store) begin
              r_state    <= S_WRITE;
              r_mem_data <= w_merge;
              r_cnt      <= CNT_LAST;
            end else begin
              r_state <= S_RESP;
              r_rdata <= w_load_data;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_WRITE: begin
          if (w_cnt_done) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FAULT: begin
          r_state <= S_RESP;
          r_fault <= 1'b1;
        end
        S_RESP: begin
          // Response fields only carry meaning during the pulse.
          r_state <= S_IDLE;
          r_rdata <= 32'd0;
          r_fault <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Everything below decodes registered state, so the memory port only
  // moves on clock edges (or asynchronously on reset).
  assign bus.req_ready_o  = (r_state == S_IDLE);
  assign bus.resp_valid_o = (r_state == S_RESP);
  assign bus.rdata_o      = r_rdata;
  assign bus.fault_o      = r_fault;
  assign bus.mem_en_o     = (r_state == S_READ) || (r_state == S_WRITE);
  assign bus.mem_wr_en_o  = (r_state == S_WRITE);
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_data_o   = r_mem_data;
  assign dbg_state_o      = r_state;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the execute stage and `dataMemory`. Accepts one load/store request at a time and decodes RV32I `funct3`. Drives a fixed-latency, word-wide, byte-addressed memory port. Loads are sign/zero-extended; byte and halfword stores are done as read-modify-write, because the memory writes 4 bytes per access.

## Interface
Parameters:
- `MEM_LATENCY`, 6: cycles each memory access is held (`mem_en_o`, address and data stable); read data is captured on the last edge; legal range ≥ 2.
- `ADDR_W`, 12: memory address width; the upper address bits are ignored.

Ports (clock and reset first):
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_i`  in  1  asynchronous, active-low reset (0 = reset).
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  unit idle; a request is accepted when `req_valid_i & req_ready_o` at a rising edge.
- `is_store_i`  in  1  1 = store, 0 = load.
- `funct3_i`  in  3  000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  store data; the low byte or halfword is used for B/H.
- `resp_valid_o`  out  1  one-cycle pulse when the operation completes.
- `rdata_o`  out  32  extended load data; valid with `resp_valid_o`; 0 for stores and faults.
- `fault_o`  out  1  misaligned access or illegal `funct3`; valid with `resp_valid_o`.
- `mem_en_o`  out  1  memory access enable.
- `mem_wr_en_o`  out  1  write strobe; asserted only while `mem_en_o`.
- `mem_addr_o`  out  `ADDR_W`  `addr_i[ADDR_W-1:0]` of the accepted request.
- `mem_data_o`  out  32  write word.
- `mem_data_i`  in  32  read word; `mem_data_i[7:0]` is the byte at `mem_addr_o`.

## Operation
- All request fields are registered on acceptance; the inputs are don't-care afterwards.
- Fault conditions:
  - H/HU with `addr[0]=1`;
  - W with `addr[1:0]≠0`;
  - `funct3` 011, 110 or 111;
  - store with BU/HU.
- States:
  - IDLE: `req_ready_o=1`; on accept go to FAULT, READ (load, SB, SH) or WRITE (SW).
  - READ: `mem_en_o=1`, `mem_wr_en_o=0`; held for `MEM_LATENCY` cycles. On the last edge, capture `mem_data_i`, then go to RESP (load) or WRITE (SB/SH).
  - WRITE: `mem_en_o=1`, `mem_wr_en_o=1`, `mem_data_o` = merged word; held for `MEM_LATENCY` cycles, then go to RESP.
  - FAULT: one cycle, no memory access, then go to RESP with `fault_o=1`.
  - RESP: `resp_valid_o=1` for one cycle, then go to IDLE. There is no backpressure.
- Merge rules:
  - SB: `{rd[31:8], wdata[7:0]}`.
  - SH: `{rd[31:16], wdata[15:0]}`.
  - SW: `wdata`.
- Load extension:
  - B: sign-extend `rd[7:0]`.
  - BU: zero-extend `rd[7:0]`.
  - H: sign-extend `rd[15:0]`.
  - HU: zero-extend `rd[15:0]`.
  - W: `rd`.
- Latency counter: `ceil(log2(MEM_LATENCY))+1` bits; reloads on every entry to READ or WRITE.
- Near the top of memory, byte addresses `mem_addr_o+1..+3` wrap modulo 2^`ADDR_W` inside the memory. An RMW rewrites those bytes with their own values, so this is benign.

## Timing
- Accept at edge E0. `mem_*` outputs change only on edges, never combinationally from the inputs.
- Load: `mem_en_o` high for cycles E0..E`L` (L = `MEM_LATENCY`); data captured at E`L`; `resp_valid_o` high E`L`..E`L+1`; `req_ready_o` high again after E`L+1`.
- SW: same timing as a load.
- SB/SH: READ for L cycles, then WRITE for L cycles back-to-back, with `mem_en_o` staying high; `resp_valid_o` high E`2L`..E`2L+1`.
- Fault: `resp_valid_o` high E1..E2; `mem_en_o` never asserts.
- `req_ready_o` is 0 from E0 until the cycle after RESP; a request held across RESP is accepted on the first edge in IDLE.
- Reset (`reset_i=0`), at any time including mid-access:
  - state → IDLE;
  - `req_ready_o=1`;
  - `resp_valid_o`, `fault_o`, `mem_en_o`, `mem_wr_en_o` = 0;
  - `rdata_o`, `mem_addr_o`, `mem_data_o` = 0;
  - the aborted operation produces no response.

## Test plan
- Preload mem[0x100..0x103]=`{0x80,0x7F,0x34,0x12}`; LW 0x100 → `rdata_o`=0x12347F80 at E`L+1`, `fault_o`=0.
- LB 0x100 → 0xFFFFFF80; LBU 0x100 → 0x00000080; LH 0x102 → 0x00001234.
- SB 0x101 with `wdata`=0xAABBCCDD, then LW 0x100 → 0x1234DD80. Check READ+WRITE span 2L cycles and `mem_wr_en_o` is high only in the last L cycles.
- LW 0x102 and LH 0x101 → `fault_o`=1, `rdata_o`=0, response at E1, `mem_en_o` stays 0; `funct3`=011 → fault.
- Pull `reset_i` low mid-WRITE of an SW → all outputs at reset values asynchronously, no `resp_valid_o`. After release, a new LW is accepted on the first edge.
- Back-to-back: hold `req_valid_i` high for two LWs → the second is accepted the cycle after the first `resp_valid_o`; `mem_en_o` drops for exactly 2 cycles between them.
